// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Sequencing controller for a classic 5-stage pipeline (IF, ID, EX, MEM, WB).
// Drives the load enables and flush controls of the IF/ID, ID/EX, EX/MEM and
// MEM/WB registers and the PC.
//   * Detects load-use hazards and inserts a bubble into ID/EX.
//   * Flushes IF/ID and ID/EX when a branch/jump resolves taken in EX.
//   * Freezes the entire pipeline while data memory has not completed.
//   * Runs a fixed-length drain sequence after reset release.
// The register enables also serve as clock-gate enables, so an enable of 0
// must really mean "this register does not change".
//
// Parameters
//   INIT_CYCLES  cycles after reset release with PC held and IF/ID, ID/EX
//                flushed (must be >= 1)
//   MEM_TIMEOUT  consecutive frozen cycles that set mem_timeout
//   CNT_W        width of the saturating performance counters
//
// Ports
//   clk          in   1      clock, all state updates on the rising edge
//   reset_n      in   1      asynchronous, active-low reset
//   id_rs1       in   5      rs1 of the instruction in ID
//   id_rs2       in   5      rs2 of the instruction in ID
//   id_use_rs1   in   1      ID instruction reads rs1
//   id_use_rs2   in   1      ID instruction reads rs2
//   ex_rd        in   5      rd of the instruction in EX
//   ex_mem_read  in   1      EX instruction is a load
//   ex_br_taken  in   1      branch/jump resolved taken in EX this cycle
//   dmem_req     in   1      MEM stage is accessing data memory this cycle
//   dmem_ready   in   1      data memory completes the access this cycle
//   pc_en        out  1      PC update enable
//   if_id_en     out  1      IF/ID load enable
//   if_id_flush  out  1      IF/ID loads a NOP at the next edge
//   id_ex_en     out  1      ID/EX load enable
//   id_ex_flush  out  1      ID/EX loads a bubble at the next edge
//   ex_mem_en    out  1      EX/MEM load enable
//   mem_wb_en    out  1      MEM/WB load enable
//   stall_cnt    out  CNT_W  cycles with pc_en=0 outside INIT, saturating
//   flush_cnt    out  CNT_W  taken-branch flush events, saturating
//   mem_timeout  out  1      sticky: memory freeze lasted MEM_TIMEOUT cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  // init_cnt only has to reach INIT_CYCLES-1.
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  // wait_cnt saturates at MEM_TIMEOUT, so it needs to hold that value.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  // ---------------------------------------------------------------------------
  // Hazard decode
  // ---------------------------------------------------------------------------
  logic            freeze;
  logic            load_use;
  logic            active;
  logic [1:0][4:0] src_reg;
  logic [1:0]      src_use;
  logic [1:0]      src_hit;

  assign src_reg[0] = id_rs1;
  assign src_reg[1] = id_rs2;
  assign src_use[0] = id_use_rs1;
  assign src_use[1] = id_use_rs2;

  // One comparator per ID source operand against the load destination.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] & (src_reg[gi] == ex_rd);
    end
  endgenerate

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read & (ex_rd != 5'd0) & (|src_hit);

  // A ready without a request is meaningless and must not release anything.
  assign freeze = dmem_req & ~dmem_ready;

  // RUN and MEM_WAIT share the same priority evaluation.
  assign active = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

  // ---------------------------------------------------------------------------
  // State register and bookkeeping registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    init_cnt_d = '0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        // A taken branch seen during a freeze is simply re-evaluated once the
        // memory releases, because EX is held and still presents it.
        state_d = freeze ? ST_MEM_WAIT : ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (Mealy: state plus current inputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    // Drain values: PC held, front end flushed, back end allowed to empty.
    pc_en       = 1'b0;
    if_id_en    = 1'b1;
    if_id_flush = 1'b1;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (freeze) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          if_id_flush = 1'b0;
          id_ex_en    = 1'b0;
          id_ex_flush = 1'b0;
          ex_mem_en   = 1'b0;
          mem_wb_en   = 1'b0;
        end else if (ex_br_taken) begin
          // The ID instruction is squashed, so any hazard it has is moot.
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, let the load advance, bubble into EX.
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          if_id_flush = 1'b0;
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
        end else begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b0;
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b0;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and timeout flag
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;

    if (active && !pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    if (active && !freeze && ex_br_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // wait_cnt counts every frozen edge of the current freeze, including the
    // RUN cycle that enters MEM_WAIT, so it equals the number of frozen edges
    // seen so far. Any non-frozen active cycle leaves MEM_WAIT and clears it.
    if (active && freeze) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;
      if (wait_cnt_d == WAIT_LIMIT) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. Each scenario task builds a
// stimulus table; per cycle the expected outputs and counters are pushed to a
// scoreboard queue when the inputs are driven and popped and compared once the
// combinational outputs have settled, before the next rising edge.
// Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
// ex_mem_en, mem_wb_en}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int INIT_CYCLES = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 5;

  localparam logic [6:0] EN_INIT    = 7'b0111111;
  localparam logic [6:0] EN_FREEZE  = 7'b0000000;
  localparam logic [6:0] EN_BRANCH  = 7'b1111111;
  localparam logic [6:0] EN_LOADUSE = 7'b0001111;
  localparam logic [6:0] EN_NORMAL  = 7'b1101011;

  logic             clk;
  logic             reset_n;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_br_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout;

  pipeline_hazard_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_br_taken (ex_br_taken),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_en    (id_ex_en),
    .id_ex_flush (id_ex_flush),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .mem_timeout (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] en_obs;
  assign en_obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] en;
    logic       inc_s;
    logic       inc_f;
    logic       set_t;
  } stim_t;

  typedef struct {
    logic [6:0]       en;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic             tmo;
  } exp_t;

  exp_t             sb_q[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_flush;
  logic             exp_tmo;

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic br, input logic req,
                               input logic rdy, input logic [6:0] en,
                               input logic inc_s, input logic inc_f, input logic set_t);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
    s.mr = mr; s.br = br; s.req = req; s.rdy = rdy; s.en = en;
    s.inc_s = inc_s; s.inc_f = inc_f; s.set_t = set_t;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_rs1      = s.rs1;
    id_rs2      = s.rs2;
    id_use_rs1  = s.u1;
    id_use_rs2  = s.u2;
    ex_rd       = s.rd;
    ex_mem_read = s.mr;
    ex_br_taken = s.br;
    dmem_req    = s.req;
    dmem_ready  = s.rdy;
  endtask

  task automatic push_exp(input logic [6:0] en);
    exp_t e;
    e.en    = en;
    e.stall = exp_stall;
    e.flush = exp_flush;
    e.tmo   = exp_tmo;
    sb_q.push_back(e);
  endtask

  // Wait for the rising edge, account for what that edge should do, and
  // return on the following falling edge ready for the next drive.
  task automatic advance(input stim_t s);
    @(posedge clk);
    if (s.inc_s && (exp_stall != {CNT_W{1'b1}})) exp_stall = exp_stall + 1'b1;
    if (s.inc_f && (exp_flush != {CNT_W{1'b1}})) exp_flush = exp_flush + 1'b1;
    if (s.set_t) exp_tmo = 1'b1;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // T1: reset hold, INIT drain ignores all inputs, then RUN
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    stim_t tbl[$];
    exp_t  e;
    reset_n = 1'b0;
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL, 1'b0, 1'b0, 1'b0));
    exp_stall = '0; exp_flush = '0; exp_tmo = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push_exp(EN_INIT);
    #2;
    e = sb_q.pop_front();
    checks++;
    if ({en_obs, stall_cnt, flush_cnt, mem_timeout} !== {e.en, e.stall, e.flush, e.tmo}) begin
      errors++;
      $display("FAIL reset_hold: got en=%b stall=%0d flush=%0d tmo=%b, want en=%b stall=%0d flush=%0d tmo=%b",
               en_obs, stall_cnt, flush_cnt, mem_timeout, e.en, e.stall, e.flush, e.tmo);
    end else begin
      $display("reset_hold en=%b stall=%0d flush=%0d tmo=%b", en_obs, stall_cnt, flush_cnt, mem_timeout);
    end
    @(negedge clk);
    reset_n = 1'b1;
    // Hazard, branch and freeze all asserted during INIT: must be ignored.
    for (int i = 0; i < INIT_CYCLES; i++)
      tbl.push_back(mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, EN_INIT, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL, 1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      push_exp(tbl[i].en);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({en_obs, stall_cnt, flush_cnt, mem_timeout} !== {e.en, e.stall, e.flush, e.tmo}) begin
        errors++;
        $display("FAIL init_seq[%0d]: got en=%b stall=%0d flush=%0d tmo=%b, want en=%b stall=%0d flush=%0d tmo=%b",
                 i, en_obs, stall_cnt, flush_cnt, mem_timeout, e.en, e.stall, e.flush, e.tmo);
      end else begin
        $display("init_seq[%0d] en=%b stall=%0d flush=%0d tmo=%b", i, en_obs, stall_cnt, flush_cnt, mem_timeout);
      end
      advance(tbl[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // T2/T3: load-use detection on both operands, x0 exemption, branch priority
  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, EN_LOADUSE, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EN_NORMAL,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, EN_LOADUSE, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, EN_NORMAL,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, EN_BRANCH,  1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL,  1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      push_exp(tbl[i].en);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({en_obs, stall_cnt, flush_cnt, mem_timeout} !== {e.en, e.stall, e.flush, e.tmo}) begin
        errors++;
        $display("FAIL load_use[%0d]: got en=%b stall=%0d flush=%0d tmo=%b, want en=%b stall=%0d flush=%0d tmo=%b",
                 i, en_obs, stall_cnt, flush_cnt, mem_timeout, e.en, e.stall, e.flush, e.tmo);
      end else begin
        $display("load_use[%0d] en=%b stall=%0d flush=%0d tmo=%b", i, en_obs, stall_cnt, flush_cnt, mem_timeout);
      end
      advance(tbl[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // T4: memory freeze and release, ready-without-request, freeze priority
  // ---------------------------------------------------------------------------
  task automatic test_mem_freeze();
    stim_t tbl[$];
    exp_t  e;
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EN_FREEZE, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, EN_NORMAL,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EN_NORMAL,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, EN_FREEZE,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, EN_BRANCH,  1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, EN_FREEZE,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, EN_LOADUSE, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL,  1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      push_exp(tbl[i].en);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({en_obs, stall_cnt, flush_cnt, mem_timeout} !== {e.en, e.stall, e.flush, e.tmo}) begin
        errors++;
        $display("FAIL mem_freeze[%0d]: got en=%b stall=%0d flush=%0d tmo=%b, want en=%b stall=%0d flush=%0d tmo=%b",
                 i, en_obs, stall_cnt, flush_cnt, mem_timeout, e.en, e.stall, e.flush, e.tmo);
      end else begin
        $display("mem_freeze[%0d] en=%b stall=%0d flush=%0d tmo=%b", i, en_obs, stall_cnt, flush_cnt, mem_timeout);
      end
      advance(tbl[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // T5: timeout sets after the 8th frozen edge and is sticky after release
  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    stim_t tbl[$];
    exp_t  e;
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EN_FREEZE,
                       1'b1, 1'b0, (k == MEM_TIMEOUT - 1)));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, EN_NORMAL, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL, 1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      push_exp(tbl[i].en);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({en_obs, stall_cnt, flush_cnt, mem_timeout} !== {e.en, e.stall, e.flush, e.tmo}) begin
        errors++;
        $display("FAIL timeout[%0d]: got en=%b stall=%0d flush=%0d tmo=%b, want en=%b stall=%0d flush=%0d tmo=%b",
                 i, en_obs, stall_cnt, flush_cnt, mem_timeout, e.en, e.stall, e.flush, e.tmo);
      end else begin
        $display("timeout[%0d] en=%b stall=%0d flush=%0d tmo=%b", i, en_obs, stall_cnt, flush_cnt, mem_timeout);
      end
      advance(tbl[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // T6: clean reset, build stall_cnt=5 in MEM_WAIT, then asynchronous reset
  // mid-cycle and a repeated INIT sequence
  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_wait();
    stim_t tbl[$];
    stim_t post[$];
    exp_t  e;
    // Clearing reset: also shows the sticky timeout from before is cleared.
    reset_n = 1'b0;
    exp_stall = '0; exp_flush = '0; exp_tmo = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < INIT_CYCLES; k++)
      tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_INIT, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EN_FREEZE, 1'b1, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      push_exp(tbl[i].en);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({en_obs, stall_cnt, flush_cnt, mem_timeout} !== {e.en, e.stall, e.flush, e.tmo}) begin
        errors++;
        $display("FAIL pre_reset[%0d]: got en=%b stall=%0d flush=%0d tmo=%b, want en=%b stall=%0d flush=%0d tmo=%b",
                 i, en_obs, stall_cnt, flush_cnt, mem_timeout, e.en, e.stall, e.flush, e.tmo);
      end else begin
        $display("pre_reset[%0d] en=%b stall=%0d flush=%0d tmo=%b", i, en_obs, stall_cnt, flush_cnt, mem_timeout);
      end
      advance(tbl[i]);
    end
    // Still frozen in MEM_WAIT with stall_cnt=5; pull reset between edges.
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EN_FREEZE, 1'b0, 1'b0, 1'b0));
    #2;
    reset_n = 1'b0;
    exp_stall = '0; exp_flush = '0; exp_tmo = 1'b0;
    push_exp(EN_INIT);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({en_obs, stall_cnt, flush_cnt, mem_timeout} !== {e.en, e.stall, e.flush, e.tmo}) begin
      errors++;
      $display("FAIL async_reset: got en=%b stall=%0d flush=%0d tmo=%b, want en=%b stall=%0d flush=%0d tmo=%b",
               en_obs, stall_cnt, flush_cnt, mem_timeout, e.en, e.stall, e.flush, e.tmo);
    end else begin
      $display("async_reset en=%b stall=%0d flush=%0d tmo=%b", en_obs, stall_cnt, flush_cnt, mem_timeout);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < INIT_CYCLES; k++)
      post.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EN_INIT, 1'b0, 1'b0, 1'b0));
    post.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL, 1'b0, 1'b0, 1'b0));
    foreach (post[i]) begin
      apply(post[i]);
      push_exp(post[i].en);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({en_obs, stall_cnt, flush_cnt, mem_timeout} !== {e.en, e.stall, e.flush, e.tmo}) begin
        errors++;
        $display("FAIL post_reset[%0d]: got en=%b stall=%0d flush=%0d tmo=%b, want en=%b stall=%0d flush=%0d tmo=%b",
                 i, en_obs, stall_cnt, flush_cnt, mem_timeout, e.en, e.stall, e.flush, e.tmo);
      end else begin
        $display("post_reset[%0d] en=%b stall=%0d flush=%0d tmo=%b", i, en_obs, stall_cnt, flush_cnt, mem_timeout);
      end
      advance(post[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Counter saturation: long freeze, then back-to-back taken branches
  // ---------------------------------------------------------------------------
  task automatic test_saturation();
    stim_t tbl[$];
    exp_t  e;
    for (int k = 0; k < 35; k++)
      tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, EN_FREEZE,
                       1'b1, 1'b0, (k == MEM_TIMEOUT - 1)));
    for (int k = 0; k < 34; k++)
      tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, EN_BRANCH, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EN_NORMAL, 1'b0, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      push_exp(tbl[i].en);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({en_obs, stall_cnt, flush_cnt, mem_timeout} !== {e.en, e.stall, e.flush, e.tmo}) begin
        errors++;
        $display("FAIL saturate[%0d]: got en=%b stall=%0d flush=%0d tmo=%b, want en=%b stall=%0d flush=%0d tmo=%b",
                 i, en_obs, stall_cnt, flush_cnt, mem_timeout, e.en, e.stall, e.flush, e.tmo);
      end else begin
        $display("saturate[%0d] en=%b stall=%0d flush=%0d tmo=%b", i, en_obs, stall_cnt, flush_cnt, mem_timeout);
      end
      advance(tbl[i]);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_rd       = '0;
    ex_mem_read = 1'b0;
    ex_br_taken = 1'b0;
    dmem_req    = 1'b0;
    dmem_ready  = 1'b0;
    exp_stall   = '0;
    exp_flush   = '0;
    exp_tmo     = 1'b0;
    test_reset();
    test_load_use();
    test_mem_freeze();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
